// File: rtl/axil_rr_arbiter.sv
// AXI4-Lite N:1 arbiter with independent round-robin write and read paths.
// Each path owns one transaction at a time; the granted master is forwarded combinationally.
module axil_rr_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned IS_64_BIT      = 0,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    localparam int unsigned DW = (IS_64_BIT != 0) ? 64 : 32,
    localparam int unsigned SW = DW / 8,
    localparam int unsigned GW = $clog2(NUM_MASTERS)
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]                m_awvalid,
    output logic [NUM_MASTERS-1:0]                m_awready,
    input  logic [NUM_MASTERS*DW-1:0]             m_wdata,
    input  logic [NUM_MASTERS*SW-1:0]             m_wstrb,
    input  logic [NUM_MASTERS-1:0]                m_wvalid,
    output logic [NUM_MASTERS-1:0]                m_wready,
    output logic [NUM_MASTERS*2-1:0]              m_bresp,
    output logic [NUM_MASTERS-1:0]                m_bvalid,
    input  logic [NUM_MASTERS-1:0]                m_bready,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]                m_arvalid,
    output logic [NUM_MASTERS-1:0]                m_arready,
    output logic [NUM_MASTERS*DW-1:0]             m_rdata,
    output logic [NUM_MASTERS*2-1:0]              m_rresp,
    output logic [NUM_MASTERS-1:0]                m_rvalid,
    input  logic [NUM_MASTERS-1:0]                m_rready,
    output logic [AXI_ADDR_WIDTH-1:0]             s_awaddr,
    output logic                                  s_awvalid,
    input  logic                                  s_awready,
    output logic [DW-1:0]                         s_wdata,
    output logic [SW-1:0]                         s_wstrb,
    output logic                                  s_wvalid,
    input  logic                                  s_wready,
    input  logic [1:0]                            s_bresp,
    input  logic                                  s_bvalid,
    output logic                                  s_bready,
    output logic [AXI_ADDR_WIDTH-1:0]             s_araddr,
    output logic                                  s_arvalid,
    input  logic                                  s_arready,
    input  logic [DW-1:0]                         s_rdata,
    input  logic [1:0]                            s_rresp,
    input  logic                                  s_rvalid,
    output logic                                  s_rready,
    output logic                                  wr_busy,
    output logic                                  rd_busy,
    output logic [GW-1:0]                         wr_grant,
    output logic [GW-1:0]                         rd_grant
);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_t;

    wr_state_t     wr_state;
    rd_state_t     rd_state;
    logic [GW-1:0] wr_ptr;
    logic [GW-1:0] rd_ptr;
    logic          aw_done;
    logic          w_done;

    // First requester strictly above ptr, else wrap to the lowest requester.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [GW-1:0] ptr);
        logic          found;
        logic [GW-1:0] pick;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && (GW'(i) > ptr)) begin
                pick  = GW'(i);
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i]) begin
                pick  = GW'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            wr_ptr   <= GW'(NUM_MASTERS - 1);
            wr_grant <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (|m_awvalid) begin
                    wr_grant <= rr_pick(m_awvalid, wr_ptr);
                    wr_state <= W_REQ;
                end
                W_REQ: begin
                    if (s_awvalid && s_awready) aw_done <= 1'b1;
                    if (s_wvalid && s_wready)   w_done  <= 1'b1;
                    if ((aw_done || (s_awvalid && s_awready)) &&
                        (w_done  || (s_wvalid && s_wready)))
                        wr_state <= W_RESP;
                end
                W_RESP: if (s_bvalid && s_bready) begin
                    wr_ptr   <= wr_grant;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
            rd_ptr   <= GW'(NUM_MASTERS - 1);
            rd_grant <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (|m_arvalid) begin
                    rd_grant <= rr_pick(m_arvalid, rd_ptr);
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (s_arvalid && s_arready) rd_state <= R_RESP;
                R_RESP: if (s_rvalid && s_rready) begin
                    rd_ptr   <= rd_grant;
                    rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == wr_grant) begin
                if (wr_state == W_REQ) begin
                    s_awaddr     = m_awaddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    s_awvalid    = m_awvalid[i] & ~aw_done;
                    m_awready[i] = s_awready & ~aw_done;
                    s_wdata      = m_wdata[i*DW +: DW];
                    s_wstrb      = m_wstrb[i*SW +: SW];
                    s_wvalid     = m_wvalid[i] & ~w_done;
                    m_wready[i]  = s_wready & ~w_done;
                end
                if (wr_state == W_RESP) begin
                    m_bresp[i*2 +: 2] = s_bresp;
                    m_bvalid[i]       = s_bvalid;
                    s_bready          = m_bready[i];
                end
            end
        end
    end

    always_comb begin
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == rd_grant) begin
                if (rd_state == R_ADDR) begin
                    s_araddr     = m_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    s_arvalid    = m_arvalid[i];
                    m_arready[i] = s_arready;
                end
                if (rd_state == R_RESP) begin
                    m_rdata[i*DW +: DW] = s_rdata;
                    m_rresp[i*2 +: 2]   = s_rresp;
                    m_rvalid[i]         = s_rvalid;
                    s_rready            = m_rready[i];
                end
            end
        end
    end

    always_comb begin
        wr_busy = (wr_state != W_IDLE);
        rd_busy = (rd_state != R_IDLE);
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter with three masters: per-cycle vector table
// plus hand-written reset and fairness sequences.
module tb_axil_rr_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam logic [1:0]  BRESP = 2'b01;
    localparam logic [1:0]  RRESP = 2'b10;
    localparam logic [31:0] RDATA = 32'hDEADBEEF;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N*AW-1:0] m_awaddr;
    logic [N-1:0]    m_awvalid, m_awready;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_wvalid, m_wready;
    logic [N*2-1:0]  m_bresp;
    logic [N-1:0]    m_bvalid, m_bready;
    logic [N*AW-1:0] m_araddr;
    logic [N-1:0]    m_arvalid, m_arready;
    logic [N*DW-1:0] m_rdata;
    logic [N*2-1:0]  m_rresp;
    logic [N-1:0]    m_rvalid, m_rready;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic            s_awvalid, s_awready, s_wvalid, s_wready;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [SW-1:0]   s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic            s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic            wr_busy, rd_busy;
    logic [1:0]      wr_grant, rd_grant;

    axil_rr_arbiter #(.NUM_MASTERS(N), .IS_64_BIT(0), .AXI_ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    always #5 aclk = ~aclk;

    // Observed control outputs, packed in the same order as vec_t.exp.
    logic [25:0] obs;
    assign obs = {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready,
                  wr_busy, rd_busy, wr_grant, rd_grant};

    typedef struct {
        logic [2:0]  awv, wv, br, arv, rr;
        logic        awr, wr, bv, arr, rv;
        logic [25:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] awaddr_t[N];
    logic [31:0] wdata_t[N];
    logic [3:0]  wstrb_t[N];
    logic [31:0] araddr_t[N];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(
        input logic [2:0] awv, wv, br, arv, rr,
        input logic awr, wr, bv, arr, rv,
        input logic [2:0] eawr, ewr, ebv, earr, erv,
        input logic esaw, esw, esbr, esar, esrr, ewb, erb,
        input logic [1:0] ewg, erg);
        vec_t v;
        v.awv = awv; v.wv = wv; v.br = br; v.arv = arv; v.rr = rr;
        v.awr = awr; v.wr = wr; v.bv = bv; v.arr = arr; v.rv = rv;
        v.exp = {eawr, ewr, ebv, earr, erv, esaw, esw, esbr, esar, esrr, ewb, erb, ewg, erg};
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m_awvalid = v.awv; m_wvalid = v.wv; m_bready = v.br;
        m_arvalid = v.arv; m_rready = v.rr;
        s_awready = v.awr; s_wready = v.wr; s_bvalid = v.bv;
        s_arready = v.arr; s_rvalid = v.rv;
    endtask

    task automatic check_vec(input string name, input vec_t v);
        logic [5:0]  eb;
        logic [95:0] er;
        logic [5:0]  err_resp;
        chk({name, " ctl"}, 128'(obs), 128'(v.exp));
        if (v.exp[10]) chk({name, " awaddr"}, 128'(s_awaddr), 128'(awaddr_t[v.exp[3:2]]));
        if (v.exp[9])  chk({name, " wdata"}, 128'({s_wstrb, s_wdata}),
                           128'({wstrb_t[v.exp[3:2]], wdata_t[v.exp[3:2]]}));
        if (v.exp[7])  chk({name, " araddr"}, 128'(s_araddr), 128'(araddr_t[v.exp[1:0]]));
        eb = '0; er = '0; err_resp = '0;
        for (int i = 0; i < 3; i++) begin
            if (v.exp[17+i]) eb[i*2 +: 2] = BRESP;
            if (v.exp[11+i]) begin
                er[i*32 +: 32]    = RDATA;
                err_resp[i*2 +: 2] = RRESP;
            end
        end
        if (v.exp[19:17] != 3'b000) chk({name, " bresp"}, 128'(m_bresp), 128'(eb));
        if (v.exp[13:11] != 3'b000) chk({name, " rdata"}, 128'({m_rresp, m_rdata}), 128'({err_resp, er}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k;
        int   cyc;
        logic [1:0] order[6];

        awaddr_t = '{32'h0000_0100, 32'h0000_0010, 32'h0000_0200};
        wdata_t  = '{32'h1111_1111, 32'hA5A5_A5A5, 32'h3333_3333};
        wstrb_t  = '{4'h1, 4'hF, 4'h3};
        araddr_t = '{32'h0000_0300, 32'h0000_0044, 32'h0000_0500};
        for (int i = 0; i < 3; i++) begin
            m_awaddr[i*32 +: 32] = awaddr_t[i];
            m_wdata[i*32 +: 32]  = wdata_t[i];
            m_wstrb[i*4 +: 4]    = wstrb_t[i];
            m_araddr[i*32 +: 32] = araddr_t[i];
        end
        s_bresp = BRESP; s_rresp = RRESP; s_rdata = RDATA;

        //                awv    wv     br     arv    rr      awr wr bv arr rv   eawr   ewr    ebv    earr   erv    saw sw sbr sar srr wb rb wg rg
        vecs.push_back(mk(3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd0));
        // Master 1 alone, zero-wait slave.
        vecs.push_back(mk(3'b010,3'b010,3'b010,3'b000,3'b000, 1,1,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd0));
        vecs.push_back(mk(3'b010,3'b010,3'b010,3'b000,3'b000, 1,1,0,0,0, 3'b010,3'b010,3'b000,3'b000,3'b000, 1,1,0,0,0, 1,0, 2'd1,2'd0));
        vecs.push_back(mk(3'b000,3'b000,3'b010,3'b000,3'b000, 1,1,1,0,0, 3'b000,3'b000,3'b010,3'b000,3'b000, 0,0,1,0,0, 1,0, 2'd1,2'd0));
        vecs.push_back(mk(3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd1,2'd0));
        // Master 0 writes while master 1 reads; then B held off by m_bready[0] for 4 cycles.
        vecs.push_back(mk(3'b001,3'b001,3'b001,3'b010,3'b010, 1,1,0,1,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd1,2'd0));
        vecs.push_back(mk(3'b001,3'b001,3'b001,3'b010,3'b010, 1,1,0,1,0, 3'b001,3'b001,3'b000,3'b010,3'b000, 1,1,0,1,0, 1,1, 2'd0,2'd1));
        vecs.push_back(mk(3'b000,3'b000,3'b000,3'b000,3'b010, 1,1,1,1,1, 3'b000,3'b000,3'b001,3'b000,3'b010, 0,0,0,0,1, 1,1, 2'd0,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b000,3'b000,3'b000, 1,1,1,0,0, 3'b000,3'b000,3'b001,3'b000,3'b000, 0,0,0,0,0, 1,0, 2'd0,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b000,3'b000,3'b000, 1,1,1,0,0, 3'b000,3'b000,3'b001,3'b000,3'b000, 0,0,0,0,0, 1,0, 2'd0,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b000,3'b000,3'b000, 1,1,1,0,0, 3'b000,3'b000,3'b001,3'b000,3'b000, 0,0,0,0,0, 1,0, 2'd0,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b001,3'b000,3'b000, 1,1,1,0,0, 3'b000,3'b000,3'b001,3'b000,3'b000, 0,0,1,0,0, 1,0, 2'd0,2'd1));
        // Master 2: W accepted three cycles before AW.
        vecs.push_back(mk(3'b100,3'b100,3'b100,3'b000,3'b000, 0,1,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b100,3'b000,3'b000, 0,1,0,0,0, 3'b000,3'b100,3'b000,3'b000,3'b000, 1,1,0,0,0, 1,0, 2'd2,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b100,3'b000,3'b000, 0,1,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 1,0,0,0,0, 1,0, 2'd2,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b100,3'b000,3'b000, 0,1,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 1,0,0,0,0, 1,0, 2'd2,2'd1));
        vecs.push_back(mk(3'b100,3'b100,3'b100,3'b000,3'b000, 1,1,0,0,0, 3'b100,3'b000,3'b000,3'b000,3'b000, 1,0,0,0,0, 1,0, 2'd2,2'd1));
        vecs.push_back(mk(3'b000,3'b000,3'b100,3'b000,3'b000, 1,1,1,0,0, 3'b000,3'b000,3'b100,3'b000,3'b000, 0,0,1,0,0, 1,0, 2'd2,2'd1));
        // Master 0: AW and W stalled, then both accepted in the same cycle.
        vecs.push_back(mk(3'b001,3'b001,3'b001,3'b000,3'b000, 0,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd2,2'd1));
        vecs.push_back(mk(3'b001,3'b001,3'b001,3'b000,3'b000, 0,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 1,1,0,0,0, 1,0, 2'd0,2'd1));
        vecs.push_back(mk(3'b001,3'b001,3'b001,3'b000,3'b000, 1,1,0,0,0, 3'b001,3'b001,3'b000,3'b000,3'b000, 1,1,0,0,0, 1,0, 2'd0,2'd1));
        vecs.push_back(mk(3'b000,3'b000,3'b001,3'b000,3'b000, 0,0,1,0,0, 3'b000,3'b000,3'b001,3'b000,3'b000, 0,0,1,0,0, 1,0, 2'd0,2'd1));
        vecs.push_back(mk(3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd1));

        aresetn = 1'b0;
        drive(vecs[0]);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge aclk);
            drive(vecs[i]);
            #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in W_REQ after the AW handshake (master 1, W stalled).
        @(negedge aclk);
        v = mk(3'b010,3'b010,3'b010,3'b000,3'b000, 1,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd1);
        drive(v); #1; check_vec("rst_idle", v);
        @(negedge aclk);
        v = mk(3'b010,3'b010,3'b010,3'b000,3'b000, 1,0,0,0,0, 3'b010,3'b000,3'b000,3'b000,3'b000, 1,1,0,0,0, 1,0, 2'd1,2'd1);
        drive(v); #1; check_vec("rst_aw", v);
        @(negedge aclk);
        v = mk(3'b010,3'b010,3'b010,3'b000,3'b000, 1,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,1,0,0,0, 1,0, 2'd1,2'd1);
        drive(v); #1; check_vec("rst_awdone", v);
        aresetn = 1'b0;
        @(negedge aclk);
        v = mk(3'b010,3'b010,3'b010,3'b000,3'b000, 1,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd0);
        #1; check_vec("rst_after", v);
        v = mk(3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd0);
        drive(v);
        aresetn = 1'b1;

        // Three continuously requesting masters: priority restarts at master 0 after reset.
        order = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 40) begin
            @(negedge aclk);
            v = mk(3'b111,3'b111,3'b111,3'b000,3'b000, 1,1,1,0,0, 3'b000,3'b000,3'b000,3'b000,3'b000, 0,0,0,0,0, 0,0, 2'd0,2'd0);
            drive(v);
            #1;
            if (s_awvalid && s_awready) begin
                chk($sformatf("fair%0d", k), 128'(wr_grant), 128'(order[k]));
                k++;
            end
            cyc++;
        end
        if (k < 6) begin
            checks++;
            errors++;
            $display("FAIL fair_timeout: got %0d grants expected 6", k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
